// File: rtl/sky_fade_ctrl_pkg.sv
// Shared phase codes and fade constants for the day/night sky sequencer.
// Imported by the controller, its prescaler and the renderer stages.
package sky_pkg;

  localparam logic [1:0] PH_NIGHT = 2'd0;
  localparam logic [1:0] PH_RISE  = 2'd1;
  localparam logic [1:0] PH_DAY   = 2'd2;
  localparam logic [1:0] PH_SET   = 2'd3;

  localparam logic [7:0] FADE_MAX        = 8'd255;
  localparam logic [7:0] SUN_VISIBLE_MIN = 8'd64;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    return ph + 2'd1;
  endfunction

endpackage

// File: rtl/sky_fade_ctrl_if.sv
// Control/status bundle between display timing and the sky sequencer.
// master drives frame/en/skip, slave produces the fade state.
interface sky_fade_ctrl_if;

  logic       frame;
  logic       en;
  logic       skip;
  logic [7:0] fade_level;
  logic       direction;
  logic [1:0] phase;
  logic       step;

  modport master (
    output frame, en, skip,
    input  fade_level, direction, phase, step
  );

  modport slave (
    input  frame, en, skip,
    output fade_level, direction, phase, step
  );

endinterface

// File: rtl/sky_fade_ctrl_div.sv
// Tick prescaler: pulse on every DIV-th tick, wraps to zero on that tick.
// clr wins over tick and suppresses the pulse.
module fade_step_div #(
  parameter int unsigned CW  = 16,
  parameter int unsigned DIV = 4
) (
  input  logic clk_pix,
  input  logic rst_n,
  input  logic tick,
  input  logic clr,
  output logic pulse
);

  if (DIV < 1 || DIV > (2 ** CW) - 1) begin : g_bad_div
    $error("fade_step_div: DIV does not fit in CW bits");
  end

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);
  assign pulse   = tick & ~clr & at_last;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= at_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sky_fade_ctrl.sv
// Day/night fade sequencer: NIGHT -> RISE -> DAY -> SET, one tick per frame.
// All outputs are registered and only move on a tick or a skip pulse.
module sky_fade_ctrl
  import sky_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter int unsigned HOLD_NIGHT      = 120,
  parameter int unsigned HOLD_DAY        = 240,
  parameter int unsigned CW              = 16
) (
  input logic            clk_pix,
  input logic            rst_n,
  sky_fade_ctrl_if.slave bus
);

  logic [1:0] phase_q, phase_d;
  logic [7:0] fade_q, fade_d;
  logic       dir_q;
  logic       step_q;

  logic tick, live;
  logic pre_p, night_p, day_p;
  logic rise_p, set_p;
  logic fading;

  assign tick   = bus.frame & bus.en;
  assign live   = tick & ~bus.skip;
  assign fading = (phase_q == PH_RISE) | (phase_q == PH_SET);

  fade_step_div #(.CW(CW), .DIV(FRAMES_PER_STEP)) u_pre (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .tick    (live & fading),
    .clr     (bus.skip),
    .pulse   (pre_p)
  );

  fade_step_div #(.CW(CW), .DIV(HOLD_NIGHT)) u_night (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .tick    (live & (phase_q == PH_NIGHT)),
    .clr     (bus.skip),
    .pulse   (night_p)
  );

  fade_step_div #(.CW(CW), .DIV(HOLD_DAY)) u_day (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .tick    (live & (phase_q == PH_DAY)),
    .clr     (bus.skip),
    .pulse   (day_p)
  );

  assign rise_p = pre_p & (phase_q == PH_RISE);
  assign set_p  = pre_p & (phase_q == PH_SET);

  always_comb begin
    phase_d = phase_q;
    fade_d  = fade_q;
    if (bus.skip) begin
      phase_d = next_phase(phase_q);
      if (phase_q == PH_RISE || phase_q == PH_DAY)
        fade_d = FADE_MAX;
      else
        fade_d = '0;
    end else begin
      unique case (1'b1)
        night_p: phase_d = PH_RISE;
        day_p:   phase_d = PH_SET;
        rise_p: begin
          fade_d = fade_q + 8'd1;
          if (fade_d == FADE_MAX)
            phase_d = PH_DAY;
        end
        set_p: begin
          fade_d = fade_q - 8'd1;
          if (fade_d == '0)
            phase_d = PH_NIGHT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_NIGHT;
      fade_q  <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      fade_q  <= fade_d;
      dir_q   <= (phase_d == PH_SET);
      step_q  <= (fade_d != fade_q);
    end
  end

  // A fade step can only land on 255/0 as the phase changes, never past it.
  always_ff @(posedge clk_pix) begin
    if (rst_n && !bus.skip) begin
      if (rise_p) assert (fade_q != FADE_MAX);
      if (set_p)  assert (fade_q != 8'd0);
    end
  end

  assign bus.phase      = phase_q;
  assign bus.fade_level = fade_q;
  assign bus.direction  = dir_q;
  assign bus.step       = step_q;

endmodule
